// File: rtl/sr_hyp_unit.sv
// HYP math unit: result = floor(sqrt(a^2 + b^2)) using a shift-add multiplier
// and a restoring bit-serial square root, with a start/busy/done handshake.
module sr_hyp_unit #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int AW = 2*W + 2;
  localparam int CW = $clog2(W + 2);

  typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, SQRT, FIN} state_t;

  state_t         state;
  logic [AW-1:0]  acc;
  logic [2*W-1:0] mc;
  logic [W-1:0]   mp;
  logic [W-1:0]   b_lat;
  logic [W+1:0]   rem;
  logic [W:0]     root;
  logic [CW-1:0]  cnt;

  logic [W+3:0]   rem_sh;
  logic [W+4:0]   trial;
  logic [W:0]     root_nx;
  logic [W+1:0]   rem_nx;
  logic           unused_hi;

  assign unused_hi = ^{srcA[31:W], srcB[31:W]};

  // One root step: bring down the next two sum bits and try subtracting 4*root+1.
  always_comb begin
    rem_sh  = {rem, acc[AW-1 -: 2]};
    trial   = {1'b0, rem_sh} - {2'b00, root, 2'b01};
    root_nx = trial[W+4] ? {root[W-1:0], 1'b0} : {root[W-1:0], 1'b1};
    rem_nx  = trial[W+4] ? rem_sh[W+1:0] : trial[W+1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      b_lat  <= '0;
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mc    <= {{W{1'b0}}, srcA[W-1:0]};
            mp    <= srcA[W-1:0];
            b_lat <= srcB[W-1:0];
            acc   <= '0;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL_A;
          end
        end
        MUL_A, MUL_B: begin
          if (mp[0]) acc <= acc + {2'b00, mc};
          mc <= mc << 1;
          mp <= mp >> 1;
          if (cnt == CW'(W - 1)) begin
            cnt <= '0;
            if (state == MUL_A) begin
              // Reload the multiplier with b; the sum keeps accumulating.
              mc    <= {{W{1'b0}}, b_lat};
              mp    <= b_lat;
              state <= MUL_B;
            end else begin
              state <= SQRT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SQRT: begin
          acc  <= acc << 2;
          rem  <= rem_nx;
          root <= root_nx;
          if (cnt == CW'(W)) begin
            cnt    <= '0;
            result <= 32'(root_nx);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          // start is still held by the CPU here; restarting would be false.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_hyp_unit.sv
// Self-checking bench for sr_hyp_unit: directed boundary cases plus random
// operands checked cycle by cycle against an integer-sqrt reference.
module tb_sr_hyp_unit;

  localparam int W   = 16;
  localparam int LAT = 3*W + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  longint last_res = 0;

  sr_hyp_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint hyp_ref(input longint a, input longint b);
    longint s, r;
    a = a % (64'd1 << W);
    b = b % (64'd1 << W);
    s = a*a + b*b;
    r = longint'($sqrt(real'(s)));
    while (r*r > s) r--;
    while ((r+1)*(r+1) <= s) r++;
    return r;
  endfunction

  // Cycle 0 is the negedge where start/operands are driven; checks run
  // on every following negedge up to and including DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit keep_start, input string tag);
    longint exp;
    exp = hyp_ref(a, b);
    @(negedge clk);
    srcA = a; srcB = b; start = 1'b1;
    for (int cyc = 1; cyc <= LAT; cyc++) begin
      @(negedge clk);
      if (scramble && cyc == 3) begin
        srcA = $urandom; srcB = $urandom;
      end
      if (cyc == 1 || cyc == LAT-1 || cyc == LAT) begin
        chk({tag, " busy"}, busy, cyc <= LAT-1);
        chk({tag, " done"}, done, cyc == LAT);
        chk({tag, " result"}, result, (cyc == LAT) ? exp : last_res);
      end else if (busy !== 1'b1 || done !== 1'b0 || result !== last_res[31:0]) begin
        chk({tag, " mid busy"}, busy, 1);
        chk({tag, " mid done"}, done, 0);
        chk({tag, " mid result"}, result, last_res);
      end
    end
    last_res = exp;
    if (!keep_start) begin
      // start stays high through DONE; it must not cause a restart.
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk({tag, " no restart busy"}, busy, 0);
      chk({tag, " no restart done"}, done, 0);
      chk({tag, " held result"}, result, last_res);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; srcA = '0; srcB = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", busy, 0);

    run_op(32'd3, 32'd4, 1'b0, 1'b0, "basic");
    run_op(32'd0, 32'd0, 1'b0, 1'b0, "zero");
    run_op(32'd1, 32'd1, 1'b0, 1'b0, "one");
    run_op(32'd65535, 32'd65535, 1'b0, 1'b0, "max");
    chk("max value", result, 92680);
    run_op(32'd65535, 32'd0, 1'b0, 1'b0, "maxa");
    run_op(32'hFFFF_0003, 32'h0001_0004, 1'b1, 1'b0, "upper");
    chk("upper value", result, 5);

    run_op(32'd3, 32'd4, 1'b0, 1'b1, "b2b1");
    run_op(32'd5, 32'd12, 1'b0, 1'b0, "b2b2");
    chk("b2b value", result, 13);

    // Reset in the middle of a run.
    @(negedge clk);
    srcA = 32'd7; srcB = 32'd9; start = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("pre-abort busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    rst = 1'b0; start = 1'b0; last_res = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-abort done", done, 0);
      chk("post-abort busy", busy, 0);
    end
    run_op(32'd6, 32'd8, 1'b0, 1'b0, "fresh");

    for (int i = 0; i < 10; i++)
      run_op($urandom, $urandom, 1'b1, i[0], "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
